// File: rtl/serial_addsub.sv
// ---------------------------------------------------------------------------
// serial_addsub
//
// Bit-serial two's-complement adder/subtractor with a Start/Done/Ack
// handshake. One result bit is produced per falling edge of Clock, LSB
// first, so a result takes WIDTH cycles after the load edge. Subtraction
// uses A + ~B + 1: B is inverted at load and the carry flop is preset to 1.
//
// Parameters:
//   WIDTH  operand/result width in bits (2..32)
//   CNTW   bit-counter width, 2**CNTW must exceed WIDTH
//
// Ports:
//   Clock   in   system clock, all state changes on the falling edge
//   Resetn  in   asynchronous active-low reset
//   Start   in   request, sampled only while idle
//   Sub     in   0 = A+B, 1 = A-B, sampled with Start
//   A, B    in   WIDTH-bit two's-complement operands, sampled with Start
//   Ack     in   consumer acknowledge, only honoured while Done is high
//   Busy    out  high while bits are being shifted
//   Done    out  high while the result is valid and not yet acknowledged
//   S       out  result register (modulo 2**WIDTH)
//   Cout    out  carry out of the MSB (for subtraction 1 = no borrow)
//   Ovf     out  signed overflow
//
// Optional build macro:
//   SERIAL_ADDSUB_SAT_EN  when defined, an overflowing result is replaced by
//                         the most-positive or most-negative value, chosen
//                         by the sign of A. Ovf and Cout still report the raw
//                         flags. When undefined no saturation logic exists.
// ---------------------------------------------------------------------------
module serial_addsub #(
   parameter int WIDTH = 8,
   parameter int CNTW  = 6
) (
   input  logic             Clock,
   input  logic             Resetn,
   input  logic             Start,
   input  logic             Sub,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Ack,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             Ovf
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   ra_q, ra_d;
   logic [WIDTH-1:0]   rb_q, rb_d;
   logic [WIDTH-1:0]   s_q, s_d;
   logic [CNTW-1:0]    cnt_q, cnt_d;
   logic               carry_q, carry_d;
   logic               cout_q, cout_d;
   logic               ovf_q, ovf_d;

`ifdef SERIAL_ADDSUB_SAT_EN
   // Sign of A, kept only to pick the saturation direction.
   logic               asign_q, asign_d;
`endif

   logic               sum_bit;
   logic               carry_out;
   logic               last_bit;

   // One full-adder slice working on the current LSBs of the operand
   // shift registers and the carry flop.
   assign sum_bit   = ra_q[0] ^ rb_q[0] ^ carry_q;
   assign carry_out = (ra_q[0] & rb_q[0]) | (ra_q[0] & carry_q) | (rb_q[0] & carry_q);
   assign last_bit  = (cnt_q == CNTW'(WIDTH - 1));

   // Next-state and datapath logic. Everything holds by default; the load
   // edge captures operands, each shift edge retires one bit, and the MSB
   // edge also produces the flags. At the MSB slice carry_q is the carry
   // into the MSB and carry_out is the carry out of it, so their XOR is
   // signed overflow.
   always_comb begin
      state_d = state_q;
      ra_d    = ra_q;
      rb_d    = rb_q;
      s_d     = s_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
`ifdef SERIAL_ADDSUB_SAT_EN
      asign_d = asign_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (Start) begin
               ra_d    = A;
               rb_d    = Sub ? ~B : B;
               carry_d = Sub;
               cnt_d   = '0;
`ifdef SERIAL_ADDSUB_SAT_EN
               asign_d = A[WIDTH-1];
`endif
               state_d = ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            ra_d    = {1'b0, ra_q[WIDTH-1:1]};
            rb_d    = {1'b0, rb_q[WIDTH-1:1]};
            s_d     = {sum_bit, s_q[WIDTH-1:1]};
            carry_d = carry_out;
            cnt_d   = cnt_q + CNTW'(1);
            if (last_bit) begin
               cout_d  = carry_out;
               ovf_d   = carry_q ^ carry_out;
`ifdef SERIAL_ADDSUB_SAT_EN
               if (carry_q ^ carry_out) begin
                  s_d = asign_q ? {1'b1, {(WIDTH-1){1'b0}}}
                                : {1'b0, {(WIDTH-1){1'b1}}};
               end
`endif
               state_d = ST_DONE;
            end
         end

         ST_DONE: begin
            // Start is deliberately ignored here, even together with Ack:
            // a new operation needs Start seen while idle.
            if (Ack) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register, updated on the falling edge; reset discards any
   // operation in flight and clears every visible output.
   always_ff @(negedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= ST_IDLE;
         ra_q    <= '0;
         rb_q    <= '0;
         s_q     <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
`ifdef SERIAL_ADDSUB_SAT_EN
         asign_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ra_q    <= ra_d;
         rb_q    <= rb_d;
         s_q     <= s_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
`ifdef SERIAL_ADDSUB_SAT_EN
         asign_q <= asign_d;
`endif
      end
   end

   assign Busy = (state_q == ST_SHIFT);
   assign Done = (state_q == ST_DONE);
   assign S    = s_q;
   assign Cout = cout_q;
   assign Ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// ---------------------------------------------------------------------------
// tb_serial_addsub
//
// Directed testbench for serial_addsub. Drives an 8-bit and a 4-bit instance
// from one clock; the design acts on falling edges, so inputs are changed
// and outputs sampled 1 time unit after each falling edge. Expected values
// are hand-computed constants, with the saturated alternatives selected
// when SERIAL_ADDSUB_SAT_EN is defined.
// ---------------------------------------------------------------------------
module tb_serial_addsub;

`ifdef SERIAL_ADDSUB_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic       clock = 1'b1;
   logic       resetn;

   logic       start8, sub8, ack8;
   logic [7:0] a8, b8;
   logic       busy8, done8, cout8, ovf8;
   logic [7:0] s8;

   logic       start4, sub4, ack4;
   logic [3:0] a4, b4;
   logic       busy4, done4, cout4, ovf4;
   logic [3:0] s4;

   int         checks = 0;
   int         errors = 0;
   int         edges;

   always #5 clock = ~clock;

   serial_addsub #(.WIDTH(8), .CNTW(6)) dut8 (
      .Clock (clock), .Resetn (resetn), .Start (start8), .Sub (sub8),
      .A (a8), .B (b8), .Ack (ack8), .Busy (busy8), .Done (done8),
      .S (s8), .Cout (cout8), .Ovf (ovf8)
   );

   serial_addsub #(.WIDTH(4), .CNTW(3)) dut4 (
      .Clock (clock), .Resetn (resetn), .Start (start4), .Sub (sub4),
      .A (a4), .B (b4), .Ack (ack4), .Busy (busy4), .Done (done4),
      .S (s4), .Cout (cout4), .Ovf (ovf4)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issues one Start on the chosen instance, then counts falling edges
   // after the load edge until Done rises (bounded so it cannot hang).
   task automatic applyStimulus(input bit use4, input bit sub, input logic [7:0] a,
                                input logic [7:0] b, output int n);
      if (use4) begin
         start4 = 1'b1; sub4 = sub; a4 = a[3:0]; b4 = b[3:0];
      end else begin
         start8 = 1'b1; sub8 = sub; a8 = a; b8 = b;
      end
      @(negedge clock); #1;
      start4 = 1'b0;
      start8 = 1'b0;
      checkOutput("busy_after_load", use4 ? busy4 : busy8, 1'b1);
      n = 0;
      while (!(use4 ? done4 : done8) && n < 40) begin
         @(negedge clock); #1;
         n++;
      end
   endtask

   // Acknowledges the result and confirms Done drops.
   task automatic sendAck(input bit use4);
      if (use4) ack4 = 1'b1; else ack8 = 1'b1;
      @(negedge clock); #1;
      ack4 = 1'b0;
      ack8 = 1'b0;
      checkOutput("done_after_ack", use4 ? done4 : done8, 1'b0);
   endtask

   initial begin
      resetn = 1'b0;
      start8 = 1'b0; sub8 = 1'b0; ack8 = 1'b0; a8 = '0; b8 = '0;
      start4 = 1'b0; sub4 = 1'b0; ack4 = 1'b0; a4 = '0; b4 = '0;

      #12;
      checkOutput("rst_s8",    s8, 8'h00);
      checkOutput("rst_busy8", busy8, 1'b0);
      checkOutput("rst_done8", done8, 1'b0);
      checkOutput("rst_flags8", {cout8, ovf8}, 2'b00);
      checkOutput("rst_s4",    s4, 4'h0);
      resetn = 1'b1;
      @(negedge clock); #1;

      // 5 + 2 = 7, latency 8
      applyStimulus(1'b0, 1'b0, 8'd5, 8'd2, edges);
      checkOutput("add52_edges", edges, 8);
      checkOutput("add52_done", done8, 1'b1);
      checkOutput("add52_s", s8, 8'h07);
      checkOutput("add52_flags", {cout8, ovf8}, 2'b00);
      sendAck(1'b0);
      checkOutput("add52_s_idle", s8, 8'h07);

      // Ack while idle has no effect
      ack8 = 1'b1;
      @(negedge clock); #1;
      ack8 = 1'b0;
      checkOutput("idle_ack_state", {busy8, done8}, 2'b00);

      // 100 + 50 overflows: wraps to 0x96
      applyStimulus(1'b0, 1'b0, 8'd100, 8'd50, edges);
      checkOutput("add100_s", s8, SAT ? 8'h7F : 8'h96);
      checkOutput("add100_ovf", ovf8, 1'b1);
      checkOutput("add100_cout", cout8, 1'b0);
      sendAck(1'b0);

      // 3 - 5 = -2 with borrow
      applyStimulus(1'b0, 1'b1, 8'd3, 8'd5, edges);
      checkOutput("sub35_s", s8, 8'hFE);
      checkOutput("sub35_flags", {cout8, ovf8}, 2'b00);
      sendAck(1'b0);

      // 0 - (-128) overflows to 0x80
      applyStimulus(1'b0, 1'b1, 8'h00, 8'h80, edges);
      checkOutput("subneg_s", s8, SAT ? 8'h7F : 8'h80);
      checkOutput("subneg_flags", {cout8, ovf8}, 2'b01);
      sendAck(1'b0);

      // -128 - 1 overflows to 0x7F, no borrow
      applyStimulus(1'b0, 1'b1, 8'h80, 8'h01, edges);
      checkOutput("sub128_s", s8, SAT ? 8'h80 : 8'h7F);
      checkOutput("sub128_flags", {cout8, ovf8}, 2'b11);
      sendAck(1'b0);

      // Asynchronous reset three edges into a shift
      start8 = 1'b1; sub8 = 1'b0; a8 = 8'd5; b8 = 8'd2;
      @(negedge clock); #1;
      start8 = 1'b0;
      repeat (3) @(negedge clock);
      #2 resetn = 1'b0;
      #1;
      checkOutput("midrst_s", s8, 8'h00);
      checkOutput("midrst_state", {busy8, done8}, 2'b00);
      checkOutput("midrst_flags", {cout8, ovf8}, 2'b00);
      @(posedge clock); #1;
      resetn = 1'b1;
      @(negedge clock); #1;
      checkOutput("postrst_idle", {busy8, done8}, 2'b00);

      applyStimulus(1'b0, 1'b0, 8'd5, 8'd2, edges);
      checkOutput("fresh_edges", edges, 8);
      checkOutput("fresh_s", s8, 8'h07);
      sendAck(1'b0);

      // Start re-pulsed during SHIFT and during DONE is ignored
      start8 = 1'b1; sub8 = 1'b0; a8 = 8'd10; b8 = 8'd20;
      @(negedge clock); #1;
      start8 = 1'b0;
      edges = 0;
      repeat (3) begin
         @(negedge clock); #1;
         edges++;
      end
      start8 = 1'b1; sub8 = 1'b1; a8 = 8'd1; b8 = 8'd1;
      @(negedge clock); #1;
      edges++;
      start8 = 1'b0;
      while (!done8 && edges < 40) begin
         @(negedge clock); #1;
         edges++;
      end
      checkOutput("ign_edges", edges, 8);
      checkOutput("ign_shift_s", s8, 8'd30);
      start8 = 1'b1; a8 = 8'd99; b8 = 8'd99;
      @(negedge clock); #1;
      start8 = 1'b0;
      checkOutput("ign_done_held", done8, 1'b1);
      checkOutput("ign_done_s", s8, 8'd30);

      // Start and Ack together in DONE: back to idle only
      start8 = 1'b1; ack8 = 1'b1; a8 = 8'd7; b8 = 8'd7;
      @(negedge clock); #1;
      start8 = 1'b0; ack8 = 1'b0;
      checkOutput("startack_state", {busy8, done8}, 2'b00);
      @(negedge clock); #1;
      checkOutput("startack_no_op", {busy8, done8}, 2'b00);
      checkOutput("startack_s", s8, 8'd30);

      // 4-bit instance
      applyStimulus(1'b1, 1'b0, 8'd5, 8'd2, edges);
      checkOutput("w4_add52_edges", edges, 4);
      checkOutput("w4_add52_s", s4, 4'h7);
      checkOutput("w4_add52_flags", {cout4, ovf4}, 2'b00);
      sendAck(1'b1);

      applyStimulus(1'b1, 1'b0, 8'd7, 8'd1, edges);
      checkOutput("w4_add71_s", s4, SAT ? 4'h7 : 4'h8);
      checkOutput("w4_add71_flags", {cout4, ovf4}, 2'b01);
      sendAck(1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
